// File: rtl/rd1_ddr_addr_fifo_pkg.sv
// rtl/rd1_ddr_addr_fifo_pkg.sv - shared sizing and threshold constants for the read-channel-1 DDR address FIFO
package rd1_ddr_addr_fifo_pkg;
  localparam int DEPTH_WIDTH      = 8;
  localparam int DATA_WIDTH       = 10;
  localparam int DEPTH            = 2 ** DEPTH_WIDTH;
  localparam int ALMOST_FULL_NUM  = 31;
  localparam int ALMOST_EMPTY_NUM = 4;
endpackage

// File: rtl/rd1_ddr_addr_fifo_ram.sv
// rtl/rd1_ddr_addr_fifo_ram.sv - simple dual-port RAM, synchronous write, registered read with enable
module rd1_ddr_addr_fifo_ram
  import rd1_ddr_addr_fifo_pkg::*;
#(
  parameter int AW = DEPTH_WIDTH,
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          tb_rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rd1_ddr_addr_fifo.sv
// rtl/rd1_ddr_addr_fifo.sv - 256x10 single-clock FIFO with two-cycle registered read and level flags
module rd1_ddr_addr_fifo #(
  parameter int DEPTH_WIDTH      = rd1_ddr_addr_fifo_pkg::DEPTH_WIDTH,
  parameter int DATA_WIDTH       = rd1_ddr_addr_fifo_pkg::DATA_WIDTH,
  parameter int ALMOST_FULL_NUM  = rd1_ddr_addr_fifo_pkg::ALMOST_FULL_NUM,
  parameter int ALMOST_EMPTY_NUM = rd1_ddr_addr_fifo_pkg::ALMOST_EMPTY_NUM
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic                  almost_empty
);

  localparam logic [DEPTH_WIDTH:0] FULL_LVL = (DEPTH_WIDTH + 1)'(1 << DEPTH_WIDTH);
  localparam logic [DEPTH_WIDTH:0] AF_LVL   = (DEPTH_WIDTH + 1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_LVL   = (DEPTH_WIDTH + 1)'(ALMOST_EMPTY_NUM);

  logic [DEPTH_WIDTH-1:0] wptr, rptr;
  logic [DEPTH_WIDTH:0]   level;
  logic                   wr_acc, rd_acc, rd_pend;
  logic [DATA_WIDTH-1:0]  ram_q;

  assign wr_acc = wr_en && !wr_full;
  assign rd_acc = rd_en && !rd_empty;

  assign wr_full      = (level == FULL_LVL);
  assign rd_empty     = (level == '0);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  rd1_ddr_addr_fifo_ram #(
    .AW (DEPTH_WIDTH),
    .DW (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .tb_rst  (tb_rst),
    .wr_en   (wr_acc),
    .wr_addr (wptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rptr),
    .rd_data (ram_q)
  );

  // Output stage loads only the cycle after an accepted read, otherwise holds.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      rd_pend <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_pend <= rd_acc;
      if (rd_pend) rd_data <= ram_q;
    end
  end

endmodule

// File: tb/tb_rd1_ddr_addr_fifo.sv
// tb/tb_rd1_ddr_addr_fifo.sv - directed scoreboard bench for rd1_ddr_addr_fifo
module tb_rd1_ddr_addr_fifo;
  logic       clk = 1'b0;
  logic       tb_rst = 1'b1;
  logic [9:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       wr_full, almost_full, rd_empty, almost_empty;
  logic [9:0] rd_data;

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] fifo_q[$];
  logic       s1_v = 1'b0;
  logic [9:0] s1_d = '0;
  logic [9:0] exp_rd = '0;

  rd1_ddr_addr_fifo dut (
    .clk          (clk),
    .tb_rst       (tb_rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .wr_full      (wr_full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_empty     (rd_empty),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = fifo_q.size();
    chk("wr_full",      32'(wr_full),      32'(n == 256));
    chk("rd_empty",     32'(rd_empty),     32'(n == 0));
    chk("almost_full",  32'(almost_full),  32'(n >= 31));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 4));
    chk("rd_data",      32'(rd_data),      32'(exp_rd));
  endtask

  task automatic model_reset();
    fifo_q.delete();
    s1_v   = 1'b0;
    s1_d   = '0;
    exp_rd = '0;
  endtask

  task automatic step(input bit w, input logic [9:0] d, input bit r);
    bit         wacc, racc;
    logic [9:0] pop_d;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    wacc    = w && (fifo_q.size() != 256);
    racc    = r && (fifo_q.size() != 0);
    pop_d   = '0;
    if (racc) pop_d = fifo_q.pop_front();
    if (wacc) fifo_q.push_back(d);
    @(posedge clk);
    #1;
    if (s1_v) exp_rd = s1_d;
    s1_v = racc;
    if (racc) s1_d = pop_d;
    check_all();
  endtask

  initial begin
    #200;
    chk("rst_rd_empty",     32'(rd_empty),     32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_wr_full",      32'(wr_full),      32'd0);
    chk("rst_almost_full",  32'(almost_full),  32'd0);
    chk("rst_rd_data",      32'(rd_data),      32'd0);
    @(posedge clk);
    #1;
    tb_rst = 1'b0;
    model_reset();

    // fill past capacity: 257th word (0x2FF) must be dropped
    for (int i = 0; i < 257; i++) step(1'b1, 10'(10'h3FF - i), 1'b0);
    chk("fill_full", 32'(wr_full), 32'd1);

    // drain with one extra read; output must hold the last word
    for (int i = 0; i < 257; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("drain_hold", 32'(rd_data), 32'h300);
    chk("drain_empty", 32'(rd_empty), 32'd1);

    // simultaneous access at level 10
    for (int i = 0; i < 10; i++) step(1'b1, 10'(i + 16), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 10'(i + 100), 1'b1);
    chk("simul_level", 32'(fifo_q.size()), 32'd10);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("simul_last", 32'(rd_data), 32'd119);

    // wrap-around across pointer 255 -> 0
    for (int i = 0; i < 200; i++) step(1'b1, 10'($urandom_range(0, 1023)), 1'b0);
    for (int i = 0; i < 200; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 10'(i * 7 + 3), 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("wrap_last", 32'(rd_data), 32'(99 * 7 + 3));

    // reset mid-read at level 50 with reads in flight
    for (int i = 0; i < 50; i++) step(1'b1, 10'(i + 500), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    rd_en = 1'b1;
    @(posedge clk);
    #2;
    tb_rst = 1'b1;
    #1;
    chk("midrst_rd_empty",     32'(rd_empty),     32'd1);
    chk("midrst_rd_data",      32'(rd_data),      32'd0);
    chk("midrst_almost_empty", 32'(almost_empty), 32'd1);
    chk("midrst_almost_full",  32'(almost_full),  32'd0);
    model_reset();
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    tb_rst = 1'b0;
    step(1'b1, 10'h155, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("post_reset_word", 32'(rd_data), 32'h155);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
